// File: rtl/int_float_framer.sv
`default_nettype none
// ============================================================================
//  Module   : int_float_framer
//  Purpose  : Converts signed 32-bit integer samples to IEEE-754 single
//             precision (round-to-nearest-even), buffers them in a ping-pong
//             circular buffer and emits gap-free frames of FRAME_LEN beats.
//             Every frame is preceded by at least one idle (valid-low) cycle
//             so a downstream accumulator clears its running sum between
//             frames.
//  Ports    : clk       - clock, rising edge
//             rst       - synchronous reset, active-high
//             in_data   - signed integer sample
//             in_valid  - in_data valid
//             in_ready  - block can accept a sample (state-only, never
//                         depends on in_valid)
//             out_data  - IEEE-754 single value, 0 when out_valid is low
//             out_valid - frame beat valid
//             out_last  - final beat of a frame
//  Revision : 1.0 - initial release
// ============================================================================
module int_float_framer #(
    parameter int unsigned FRAME_LEN = 8,            // power of two, >= 2
    parameter int unsigned DEPTH     = 2 * FRAME_LEN // power of two
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_last
);

    localparam int unsigned c_ptr_w  = $clog2(DEPTH);
    localparam int unsigned c_beat_w = $clog2(FRAME_LEN);
    localparam int unsigned c_cnt_w  = c_ptr_w + 1;

    typedef enum logic [0:0] {
        ST_GAP   = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Leading-zero count of a 32-bit value; 32 for zero.
    function automatic logic [5:0] f_lzc(input logic [31:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd32;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 6'(31 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                s1_valid_q, s1_valid_d;
    logic                s1_sign_q,  s1_sign_d;
    logic [31:0]         s1_mag_q,   s1_mag_d;
    logic [5:0]          s1_lzc_q,   s1_lzc_d;
    logic                s2_valid_q, s2_valid_d;
    logic [31:0]         s2_data_q,  s2_data_d;
    logic [c_ptr_w-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [c_ptr_w-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [c_cnt_w-1:0]  occ_q,      occ_d;
    logic [c_cnt_w-1:0]  frames_q,   frames_d;
    logic [c_beat_w-1:0] beat_q,     beat_d;
    state_t              state_q,    state_d;
    logic                rdy_en_q,   rdy_en_d;
    logic [31:0]         mem_q [DEPTH];

    // ------------------------------------------------------------------------
    // Flow control: credits = DEPTH - occupancy - inflight
    // ------------------------------------------------------------------------
    logic [c_cnt_w-1:0] inflight;
    logic               in_fire;

    assign inflight = c_cnt_w'(s1_valid_q) + c_cnt_w'(s2_valid_q);
    // rdy_en_q holds in_ready low through reset and for the cycle in which
    // rst is released.
    assign in_ready = rdy_en_q && ((occ_q + inflight) < c_cnt_w'(DEPTH));
    assign in_fire  = in_valid && in_ready;

    // ------------------------------------------------------------------------
    // S1: sign, magnitude, leading-zero count
    // ------------------------------------------------------------------------
    logic [31:0] in_mag;

    always_comb begin
        // -2^31 maps to magnitude 0x80000000, which is exact as unsigned.
        in_mag     = in_data[31] ? (~in_data + 32'd1) : in_data;
        s1_valid_d = in_fire;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        s1_lzc_d   = s1_lzc_q;
        if (in_fire) begin
            s1_sign_d = in_data[31];
            s1_mag_d  = in_mag;
            s1_lzc_d  = f_lzc(in_mag);
        end
    end

    // ------------------------------------------------------------------------
    // S2: normalise, round to nearest even, pack
    // ------------------------------------------------------------------------
    logic [31:0] norm;
    logic [7:0]  exp_raw;
    logic [7:0]  exp_fin;
    logic        round_up;
    logic [24:0] mant_rnd;
    logic [22:0] frac;

    always_comb begin
        // Leading one lands on bit 31; bits [30:8] are the fraction,
        // bit 7 the guard bit and [6:0] the sticky bits.
        norm     = s1_mag_q << s1_lzc_q;
        exp_raw  = 8'd158 - {2'b00, s1_lzc_q};
        round_up = norm[7] & ((|norm[6:0]) | norm[8]);
        mant_rnd = {1'b0, norm[31:8]} + {24'd0, round_up};
        if (mant_rnd[24]) begin
            // Mantissa overflowed to 2.0: renormalise (fraction becomes 0).
            exp_fin = exp_raw + 8'd1;
            frac    = mant_rnd[23:1];
        end else begin
            exp_fin = exp_raw;
            frac    = mant_rnd[22:0];
        end
        s2_valid_d = s1_valid_q;
        // Zero input always packs to +0.
        s2_data_d  = (s1_mag_q == 32'd0) ? 32'd0 : {s1_sign_q, exp_fin, frac};
    end

    // ------------------------------------------------------------------------
    // Buffer bookkeeping and output FSM
    // ------------------------------------------------------------------------
    logic wr_en;
    logic rd_en;
    logic frame_wr_done;
    logic last_beat;

    always_comb begin
        wr_en         = s2_valid_q;
        rd_en         = (state_q == ST_BURST);
        frame_wr_done = wr_en && (wr_ptr_q[c_beat_w-1:0] == {c_beat_w{1'b1}});
        last_beat     = rd_en && (beat_q == {c_beat_w{1'b1}});

        wr_ptr_d = wr_ptr_q + c_ptr_w'(wr_en);
        rd_ptr_d = rd_ptr_q + c_ptr_w'(rd_en);
        occ_d    = occ_q + c_cnt_w'(wr_en) - c_cnt_w'(rd_en);

        frames_d = frames_q;
        if (frame_wr_done && !last_beat) begin
            frames_d = frames_q + c_cnt_w'(1);
        end else if (!frame_wr_done && last_beat) begin
            frames_d = frames_q - c_cnt_w'(1);
        end

        rdy_en_d = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 32'd0;
        case (state_q)
            ST_GAP: begin
                beat_d = '0;
                if (frames_q != '0) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                out_valid = 1'b1;
                out_data  = mem_q[rd_ptr_q];
                out_last  = last_beat;
                beat_d    = beat_q + c_beat_w'(1);
                if (last_beat) begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_GAP;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= 32'd0;
            s1_lzc_q   <= 6'd0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= 32'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            frames_q   <= '0;
            beat_q     <= '0;
            state_q    <= ST_GAP;
            rdy_en_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s1_lzc_q   <= s1_lzc_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            frames_q   <= frames_d;
            beat_q     <= beat_d;
            state_q    <= state_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

    // Storage needs no reset: pointers and counters gate every read.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr_q] <= s2_data_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_float_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_float_framer
//  Purpose  : Directed self-checking bench for int_float_framer
//             (FRAME_LEN = 4, DEPTH = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_float_framer;

    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned DEPTH     = 8;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [31:0] in_data  = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;

    int_float_framer #(
        .FRAME_LEN (FRAME_LEN),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];
    bit          mon_ignore = 1'b0;
    int          n_beats = 0;
    int          n_acc = 0;
    int          saw_low = 0;
    int          frame_start_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Exact float encoding for 1 <= v < 2^24.
    function automatic logic [31:0] small_to_float(input int unsigned v);
        int msb = 0;
        for (int i = 0; i < 24; i++) if (v[i]) msb = i;
        return {1'b0, 8'(127 + msb), 23'(v << (23 - msb))};
    endfunction

    // Output monitor: sampled on the falling edge.
    initial begin
        int  beat_idx = 0;
        bit  prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                beat_idx  = 0;
                prev_last = 1'b0;
            end else begin
                if (prev_last) check("gap_after_last", 64'(out_valid), 64'd0);
                if (beat_idx != 0) check("contiguous", 64'(out_valid), 64'd1);
                if (out_valid) begin
                    if (beat_idx == 0) frame_start_cyc = cyc;
                    check("last_flag", 64'(out_last), 64'(beat_idx == 3));
                    if (!mon_ignore) begin
                        if (exp_q.size() == 0)
                            check("unexpected_beat", 64'(exp_q.size()), 64'd1);
                        else
                            check("data", 64'(out_data), 64'(exp_q.pop_front()));
                    end
                    n_beats++;
                    beat_idx  = (beat_idx + 1) % 4;
                    prev_last = out_last;
                end else begin
                    check("idle_zero", {31'd0, out_last, out_data}, 64'd0);
                    prev_last = 1'b0;
                end
            end
        end
    end

    // All driving happens 1 time unit after a rising edge.
    task automatic send(input logic [31:0] v, input bit model, output int acc);
        int guard = 0;
        in_data  = v;
        in_valid = 1'b1;
        while (1) begin
            if (model) begin
                check("in_ready_model", 64'(in_ready), 64'((n_acc - n_beats) < 8));
                if (!in_ready) saw_low++;
            end
            if (in_ready) break;
            if (guard >= 500) begin
                check("send_timeout", 64'(in_ready), 64'd1);
                break;
            end
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        acc = cyc;
        n_acc++;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 1000) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    logic [31:0] conv_in  [8] = '{32'd1, 32'hFFFF_FFFF, 32'd3, 32'd0,
                                  32'h8000_0000, 32'd16777217, 32'd16777219, 32'h7FFF_FFFF};
    logic [31:0] conv_exp [8] = '{32'h3F80_0000, 32'hBF80_0000, 32'h4040_0000, 32'h0000_0000,
                                  32'hCF00_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h4F00_0000};
    logic [31:0] seq_exp  [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                                  32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
    logic [31:0] part_exp [4] = '{32'h42C8_0000, 32'h4348_0000, 32'h4396_0000, 32'h43C8_0000};

    initial begin
        int a0, a1, a2, a3, nb, guard;

        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        rst = 1'b0;
        check("rel_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("rel_in_ready_high", 64'(in_ready), 64'd1);

        // ---------------- conversion vectors ----------------
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(conv_exp[k]);
            repeat (3) exp_q.push_back(32'd0);
            send(conv_in[k], 1'b0, a0);
            repeat (3) send(32'd0, 1'b0, a0);
        end
        wait_drain();

        // ---------------- framing with input gaps ----------------
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(seq_exp[k]);
            send(32'(k + 1), 1'b0, a0);
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
        end
        wait_drain();

        // ---------------- back-pressure ----------------
        n_acc   = 0;
        n_beats = 0;
        saw_low = 0;
        for (int k = 1; k <= 48; k++) begin
            exp_q.push_back(small_to_float(k));
            send(32'(k), 1'b1, a0);
        end
        check("ready_fell", 64'(saw_low > 0), 64'd1);
        wait_drain();

        // ---------------- latency / throughput recovery ----------------
        for (int k = 4; k < 8; k++) exp_q.push_back(seq_exp[k]);
        send(32'd5, 1'b0, a0);
        send(32'd6, 1'b0, a1);
        send(32'd7, 1'b0, a2);
        send(32'd8, 1'b0, a3);
        check("tp_gap1", 64'(a1 - a0), 64'd1);
        check("tp_gap2", 64'(a2 - a1), 64'd1);
        check("tp_gap3", 64'(a3 - a2), 64'd1);
        wait_drain();
        check("latency", 64'(frame_start_cyc - a0), 64'd6);

        // ---------------- partial frame ----------------
        for (int k = 0; k < 4; k++) exp_q.push_back(part_exp[k]);
        send(32'd100, 1'b0, a0);
        send(32'd200, 1'b0, a0);
        send(32'd300, 1'b0, a0);
        nb = n_beats;
        repeat (100) begin @(posedge clk); #1; end
        check("partial_hold", 64'(n_beats - nb), 64'd0);
        send(32'd400, 1'b0, a0);
        wait_drain();

        // ---------------- reset mid-burst ----------------
        mon_ignore = 1'b1;
        send(32'd9,  1'b0, a0);
        send(32'd10, 1'b0, a0);
        send(32'd11, 1'b0, a0);
        send(32'd12, 1'b0, a0);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("burst_start", 64'(out_valid), 64'd1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_last",  64'(out_last),  64'd0);
        check("mid_rst_out_data",  64'(out_data),  64'd0);
        check("mid_rst_in_ready",  64'(in_ready),  64'd0);
        rst = 1'b0;
        mon_ignore = 1'b0;
        check("mid_rel_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("mid_rel_ready_high", 64'(in_ready), 64'd1);
        for (int k = 0; k < 4; k++) exp_q.push_back(seq_exp[k]);
        for (int k = 1; k <= 4; k++) send(32'(k), 1'b0, a0);
        wait_drain();
        repeat (5) begin @(posedge clk); #1; end
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got t=%0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/int_float_framer.md
Name: int_float_framer

Overview:
- Upstream feeder for the float sequence accumulator.
- Accepts signed 32-bit integer samples with a valid/ready handshake and converts each one to IEEE-754 single precision (round-to-nearest-even).
- Buffers the converted samples and emits them as gap-free frames of FRAME_LEN beats, asserting out_last on the final beat.
- Inserts at least one idle cycle (out_valid low) before every frame, because the accumulator clears its running sum on any cycle with valid low.

Parameters:
- FRAME_LEN, 8, beats per output frame; must be >= 2 and a power of two.
- DEPTH, 2*FRAME_LEN, buffer depth in words (ping-pong: one frame filling, one draining).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  32  signed two's-complement integer sample.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept a sample; a transfer occurs when in_valid and in_ready are both high.
- out_data  out  32  IEEE-754 single value; 0 when out_valid is low.
- out_valid  out  1  beat valid; drives the accumulator's valid input.
- out_last  out  1  final beat of a frame; high only together with out_valid.

Behaviour:
- Reset (rst high at an edge): out_valid=0, out_last=0, out_data=0, in_ready=0 during the reset cycle. All pointers, counters and pipeline valids are cleared; the FSM enters GAP. Reset mid-frame discards partial input frames and aborts any burst immediately. in_ready rises the cycle after rst falls.
- Conversion pipeline: 2 stages, no stall.
  - S1: register sign, magnitude, and leading-zero count.
  - S2: normalise, round to nearest even, pack, then write to the buffer.
  - A sample accepted at edge N is written at edge N+2.
- Conversion rules:
  - 0 -> 0x00000000 (never produce -0).
  - -2^31 -> 0xCF000000.
  - Magnitudes above 2^24 are rounded RNE on the bits below the 24-bit mantissa; a mantissa carry-out increments the exponent.
  - No NaN, Inf or denormal outputs are possible.
- Flow control:
  - credits = DEPTH - occupancy - inflight, where inflight is the number of S1/S2 valid entries (0..2).
  - in_ready = (credits > 0), registered-free combinational from state only; it never depends on in_valid.
  - The buffer never overflows, so there is no drop path.
- Buffer: circular array of DEPTH words with wrap-around write and read pointers of log2(DEPTH) bits. frames_ready increments when the write pointer crosses a frame boundary (write of index FRAME_LEN-1 mod FRAME_LEN). It decrements at the out_last beat. If both events happen in the same cycle, frames_ready is unchanged.
- Output FSM:
  - GAP: out_valid=0. Held for at least 1 cycle. Moves to BURST when frames_ready > 0, otherwise stays.
  - BURST: out_valid=1, out_data = buf[rd_ptr], rd_ptr increments every cycle, a beat counter counts 0..FRAME_LEN-1. out_last=1 when the counter = FRAME_LEN-1; the FSM then returns to GAP.
  - Never two back-to-back frames: there is exactly one GAP cycle minimum between an out_last beat and the next first beat.
  - The first frame after reset is preceded by at least one GAP cycle.
- Latency: with the FSM idle in GAP, the final sample of a frame accepted at edge N gives its first output beat valid in the cycle after edge N+3.
- Partial frames are held indefinitely; there is no timeout or flush.
- Input gaps (in_valid low) never produce output gaps inside a frame.
- out_data and out_last are 0 whenever out_valid is low.

Test Plan (FRAME_LEN=4):
- Conversion vectors, one per frame, padded with zeros:
  - 1 -> 0x3F800000
  - -1 -> 0xBF800000
  - 3 -> 0x40400000
  - 0 -> 0x00000000
  - -2147483648 -> 0xCF000000
  - 16777217 -> 0x4B800000 (tie, rounds to even)
  - 16777219 -> 0x4B800002
  - 2147483647 -> 0x4F000000
- Framing: stream 1,2,3,4,5,6,7,8 with random in_valid gaps. Required output: two bursts, 0x3F800000,0x40000000,0x40400000,0x40800000 then 0x40A00000..0x41000000. Each burst is 4 contiguous beats with out_last on the 4th and at least 1 out_valid-low cycle between bursts.
- Back-pressure:
  - Drive in_valid continuously and hold the output from draining by checking in_ready.
  - in_ready must fall once occupancy+inflight=8; no sample is lost or duplicated.
  - Throughput recovers to one sample/cycle after drain.
- Latency: feed 4 samples back-to-back starting at edge N from empty. Required: the first out_valid appears in the cycle after edge N+6 (final sample accepted at edge N+3, plus 3).
- Reset mid-burst:
  - Assert rst during beat 2 of a burst. Next cycle: out_valid=0, out_last=0, out_data=0, in_ready=0.
  - After release, a fresh 4-sample frame emits correctly and the pre-reset data never reappears.
- Partial frame: send 3 samples and stop. Required: out_valid stays 0 for 100 cycles; the 4th sample triggers the full 4-beat frame.
